seq_to_sim_load_ctrl: RTL

//  Load sequencer for a sequentialToSimultaneousReg instance in the BCH decoder datapath.

---
 rtl/seq_to_sim_load_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/seq_to_sim_load_ctrl.sv
// seq_to_sim_load_ctrl: load sequencer for a serial-to-parallel shift register.
// Fills SHIFT_LEN symbols, presents the word downstream, counts delivered words.
module seq_to_sim_load_ctrl #(
  parameter int SHIFT_LEN = 4,
  parameter int WCNT_W    = 16,
  localparam int FW = (SHIFT_LEN < 1) ? 1 : $clog2(SHIFT_LEN + 1)
) (
  input  logic              clk,
  input  logic              in_ctr_Arst_n,
  input  logic              in_ctr_abort,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic              out_ctr_Srst,
  output logic              out_ctr_en,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [FW-1:0]     out_fill,
  output logic [WCNT_W-1:0] out_word_cnt
);

  typedef enum logic [1:0] {
    INIT = 2'd0,
    FILL = 2'd1,
    FULL = 2'd2
  } state_t;

  localparam logic [FW-1:0] FILL_MAX = FW'(SHIFT_LEN);
  localparam logic [FW-1:0] LAST     = FW'(SHIFT_LEN - 1);
  localparam logic [FW-1:0] ONE      = FW'(1);

  if (SHIFT_LEN < 1) begin : g_bad
    $error("seq_to_sim_load_ctrl: SHIFT_LEN must be >= 1");
    assign in_rdy       = 1'b0;
    assign out_ctr_Srst = 1'b1;
    assign out_ctr_en   = 1'b0;
    assign out_vld      = 1'b0;
    assign out_fill     = '0;
    assign out_word_cnt = '0;
  end else begin : g_ctrl
    state_t             state_q;
    logic [FW-1:0]      fill_q;
    logic [WCNT_W-1:0]  cnt_q;
    logic               vld_q;

    // State, fill level, word count and word-valid flag.
    always_ff @(posedge clk or negedge in_ctr_Arst_n) begin
      if (!in_ctr_Arst_n) begin
        state_q <= INIT;
        fill_q  <= '0;
        cnt_q   <= '0;
        vld_q   <= 1'b0;
      end else if (in_ctr_abort) begin
        state_q <= FILL;
        fill_q  <= '0;
        vld_q   <= 1'b0;
      end else begin
        unique case (state_q)
          INIT: state_q <= FILL;
          FILL: begin
            if (in_vld) begin
              if (fill_q == LAST) begin
                state_q <= FULL;
                fill_q  <= FILL_MAX;
                vld_q   <= 1'b1;
              end else begin
                fill_q <= fill_q + ONE;
              end
            end
          end
          FULL: begin
            if (out_rdy) begin
              cnt_q <= cnt_q + 1'b1;
              if (in_vld) begin
                fill_q <= ONE;
                if (SHIFT_LEN != 1) begin
                  state_q <= FILL;
                  vld_q   <= 1'b0;
                end
              end else begin
                fill_q  <= '0;
                state_q <= FILL;
                vld_q   <= 1'b0;
              end
            end
          end
          default: begin
            state_q <= INIT;
            fill_q  <= '0;
            vld_q   <= 1'b0;
          end
        endcase
      end
    end

    // Handshake and shift-register controls; abort forces a clear.
    always_comb begin
      in_rdy       = 1'b0;
      out_ctr_Srst = 1'b0;
      out_ctr_en   = 1'b0;
      if (in_ctr_abort) begin
        out_ctr_Srst = 1'b1;
      end else begin
        unique case (state_q)
          INIT: out_ctr_Srst = 1'b1;
          FILL: begin
            in_rdy     = 1'b1;
            out_ctr_en = in_vld;
          end
          FULL: begin
            in_rdy     = out_rdy;
            out_ctr_en = in_vld & out_rdy;
          end
          default: out_ctr_Srst = 1'b1;
        endcase
      end
    end

    assign out_vld      = vld_q;
    assign out_fill     = fill_q;
    assign out_word_cnt = cnt_q;
  end

endmodule
